byte_store_ctrl: RTL and testbench
==================================

BYTE_STORE_CTRL -- requirements
Module: byte_store_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for mem_ack per bus phase.
REQ-002 SHALL have clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have nRst, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have store_req, input, 1, store request from the execute stage.
REQ-005 SHALL have store_byte_en, input, 1; 1 = byte store (SB), 0 = word store (SW).
REQ-006 SHALL have addr, input, 32, the byte address.
REQ-007 SHALL have reg_b, input, 32, the word store data.
REQ-008 SHALL have imm_gen_byte, input, 32, the zero-extended byte store data; only bits [7:0] are used.
REQ-009 SHALL have busy, output, 1, the pipeline stall.
REQ-010 SHALL have done, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have err, output, 1, a one-cycle error pulse.
REQ-012 SHALL have mem_addr, output, 32, the word-aligned bus address.
REQ-013 SHALL have mem_wdata, output, 32, and mem_wstrb, output, 4.
REQ-014 SHALL have mem_we, output, 1, and mem_re, output, 1.
REQ-015 SHALL have mem_rdata, input, 32, and mem_ack, input, 1.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, DONE; busy = (state != IDLE).
REQ-017 SHALL accept a request only when store_req=1 in IDLE, capturing addr, store_byte_en, reg_b and imm_gen_byte[7:0]; store_req while busy is ignored.
REQ-018 SHALL drive mem_addr = {addr[31:2], 2'b00} from the captured address.
REQ-019 SHALL reject a word store with addr[1:0] != 0: err pulses the next cycle, state stays IDLE, no bus access.
REQ-020 SHALL go IDLE->WRITE on a word store, with mem_wdata = reg_b and mem_wstrb = 4'hF.
REQ-021 SHALL use byte lane = addr[1:0] (little-endian) for byte stores.
REQ-022 SHALL hold mem_we (WRITE) or mem_re (READ) plus addr, data and strobes stable until mem_ack=1 is sampled.
REQ-023 SHALL go WRITE->DONE on mem_ack; in DONE, done=1 for exactly one cycle, then IDLE.
REQ-024 SHALL give minimum latency, for ack on the first bus cycle: request at cycle 0, mem_we at cycle 1, done at cycle 2.
REQ-025 SHALL count cycles without ack in READ/WRITE with an 8-bit+ counter cleared on each phase entry.
REQ-026 SHALL, on reaching TIMEOUT: pulse err, deassert mem_we/mem_re, return to IDLE, and not pulse done.
REQ-027 SHALL ignore mem_ack in IDLE and DONE.
REQ-028 SHALL never assert mem_we and mem_re together.
REQ-029 SHALL let done and err be mutually exclusive per request.

Reset
REQ-030 SHALL, on nRst=0 at a clock edge: state=IDLE, busy=0, done=0, err=0, mem_we=0, mem_re=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, timeout counter=0.
REQ-031 SHALL abort an in-flight bus phase on reset with no done/err pulse; the first request is accepted on the first edge with nRst=1.

Configuration
REQ-032 SHALL, with BYTE_STROBE_EN defined, handle a byte store as IDLE->WRITE with mem_wdata = byte replicated to all four lanes and mem_wstrb = 4'b0001 << lane.
REQ-033 SHALL, with BYTE_STROBE_EN undefined, handle a byte store as read-modify-write: IDLE->READ; on ack, merge byte into lane of mem_rdata; ->WRITE with mem_wstrb = 4'hF.
REQ-034 SHALL tie mem_re to 0 when BYTE_STROBE_EN is defined.

Verification
REQ-035 Word store: addr=0x100, reg_b=0xDEADBEEF, ack on first cycle -> mem_addr=0x100, wdata=0xDEADBEEF, wstrb=F, done at cycle 2.
REQ-036 Byte store with BYTE_STROBE_EN: addr=0x203, byte=0xA5 -> mem_addr=0x200, wdata=0xA5A5A5A5, wstrb=4'b1000, one write.
REQ-037 Byte store without macro: addr=0x201, byte=0x5A, rdata=0x11223344 -> read then write wdata=0x11225A44, wstrb=F, done once.
REQ-038 Misaligned SW: addr=0x102 -> err pulse, mem_we never 1, busy stays 0.
REQ-039 Timeout: TIMEOUT=4, mem_ack held 0 -> mem_we high 4 cycles, then err pulse, no done; a second store_req mid-wait is ignored.
REQ-040 Reset mid-WRITE: nRst=0 during mem_we=1 -> all outputs 0 next edge; a new request after reset completes normally.

Source files
------------

// File: rtl/byte_store_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : byte_store_ctrl
//  Description : Store unit bus controller. Issues word stores directly and
//                byte stores either as a strobed write (BYTE_STROBE_EN
//                defined) or as a read-modify-write (macro undefined). Each
//                bus phase is bounded by a TIMEOUT-cycle ack watchdog.
//  Config      : `define BYTE_STROBE_EN selects strobed byte writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_store_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        store_req,
    input  logic        store_byte_en,
    input  logic [31:0] addr,
    input  logic [31:0] reg_b,
    input  logic [31:0] imm_gen_byte,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // Watchdog is at least 8 bits wide, wider if TIMEOUT needs it.
    localparam int c_CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // Count value on which the final unacknowledged cycle of a phase ends.
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;

`ifdef BYTE_STROBE_EN
    // Strobed byte writes never read the bus.
    logic w_unused;
    assign w_unused = ^{imm_gen_byte[31:8], mem_rdata};
    assign mem_re   = 1'b0;
`else
    logic        r_mem_re;
    logic [1:0]  r_lane;
    logic [7:0]  r_byte;
    logic [31:0] w_merged;
    logic        w_unused;

    assign w_unused = ^imm_gen_byte[31:8];
    assign mem_re   = r_mem_re;

    // Insert the captured byte into its little-endian lane of the read word.
    always_comb begin
        w_merged = mem_rdata;
        case (r_lane)
            2'd0:    w_merged[7:0]   = r_byte;
            2'd1:    w_merged[15:8]  = r_byte;
            2'd2:    w_merged[23:16] = r_byte;
            default: w_merged[31:24] = r_byte;
        endcase
    end
`endif

    assign busy = (r_state != S_IDLE);

    // Main FSM: request capture, bus phases with ack watchdog, done/err pulses.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            mem_we    <= 1'b0;
`ifndef BYTE_STROBE_EN
            r_mem_re  <= 1'b0;
            r_lane    <= '0;
            r_byte    <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (store_req) begin
                        r_cnt <= '0;
                        if (!store_byte_en) begin
                            // Word stores must be naturally aligned.
                            if (addr[1:0] != 2'b00) begin
                                err <= 1'b1;
                            end else begin
                                mem_addr  <= {addr[31:2], 2'b00};
                                mem_wdata <= reg_b;
                                mem_wstrb <= 4'hF;
                                mem_we    <= 1'b1;
                                r_state   <= S_WRITE;
                            end
                        end else begin
                            mem_addr <= {addr[31:2], 2'b00};
`ifdef BYTE_STROBE_EN
                            mem_wdata <= {4{imm_gen_byte[7:0]}};
                            mem_wstrb <= 4'b0001 << addr[1:0];
                            mem_we    <= 1'b1;
                            r_state   <= S_WRITE;
`else
                            r_lane    <= addr[1:0];
                            r_byte    <= imm_gen_byte[7:0];
                            mem_wstrb <= 4'h0;
                            r_mem_re  <= 1'b1;
                            r_state   <= S_READ;
`endif
                        end
                    end
                end
`ifndef BYTE_STROBE_EN
                S_READ: begin
                    if (mem_ack) begin
                        r_mem_re  <= 1'b0;
                        mem_wdata <= w_merged;
                        mem_wstrb <= 4'hF;
                        mem_we    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_WRITE;
                    end else if (r_cnt == c_TO_LAST) begin
                        r_mem_re <= 1'b0;
                        err      <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_cnt == c_TO_LAST) begin
                        mem_we  <= 1'b0;
                        err     <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_byte_store_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_store_ctrl
//  Description : Directed self-checking bench for byte_store_ctrl
//                (TIMEOUT = 4). Byte-store expectations follow BYTE_STROBE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_store_ctrl;

    logic        clk;
    logic        nRst;
    logic        store_req;
    logic        store_byte_en;
    logic [31:0] addr;
    logic [31:0] reg_b;
    logic [31:0] imm_gen_byte;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_checks = 0;
    int n_errors = 0;

    byte_store_ctrl #(.TIMEOUT(4)) u_dut (
        .clk           (clk),
        .nRst          (nRst),
        .store_req     (store_req),
        .store_byte_en (store_byte_en),
        .addr          (addr),
        .reg_b         (reg_b),
        .imm_gen_byte  (imm_gen_byte),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic be, input logic [31:0] a, input logic [31:0] d, input logic [31:0] b);
        store_req     = 1'b1;
        store_byte_en = be;
        addr          = a;
        reg_b         = d;
        imm_gen_byte  = b;
    endtask

    initial begin
        nRst = 1'b0; store_req = 1'b0; store_byte_en = 1'b0;
        addr = '0; reg_b = '0; imm_gen_byte = '0; mem_rdata = '0; mem_ack = 1'b0;
        step(); step();

        // Reset state
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_we",    32'(mem_we), 32'd0);
        check("rst_re",    32'(mem_re), 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_addr",  mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);

        // Word store, ack on first bus cycle; request on first edge out of reset
        nRst = 1'b1;
        request(1'b0, 32'h100, 32'hDEADBEEF, 32'h0);
        step();
        store_req = 1'b0;
        check("sw_we",    32'(mem_we), 32'd1);
        check("sw_re",    32'(mem_re), 32'd0);
        check("sw_addr",  mem_addr, 32'h100);
        check("sw_wdata", mem_wdata, 32'hDEADBEEF);
        check("sw_wstrb", 32'(mem_wstrb), 32'hF);
        check("sw_busy",  32'(busy), 32'd1);
        check("sw_done1", 32'(done), 32'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("sw_done2", 32'(done), 32'd1);
        check("sw_we2",   32'(mem_we), 32'd0);
        check("sw_err2",  32'(err), 32'd0);
        step();
        check("sw_done3", 32'(done), 32'd0);
        check("sw_busy3", 32'(busy), 32'd0);

        // Ack while idle is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("idle_ack_busy", 32'(busy), 32'd0);
        check("idle_ack_done", 32'(done), 32'd0);

`ifdef BYTE_STROBE_EN
        // Strobed byte store to lane 3
        request(1'b1, 32'h203, 32'h0, 32'h000000A5);
        step();
        store_req = 1'b0;
        check("sb_we",    32'(mem_we), 32'd1);
        check("sb_re",    32'(mem_re), 32'd0);
        check("sb_addr",  mem_addr, 32'h200);
        check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        check("sb_wstrb", 32'(mem_wstrb), 32'h8);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("sb_done", 32'(done), 32'd1);
        check("sb_we2",  32'(mem_we), 32'd0);
        step();
        check("sb_done3", 32'(done), 32'd0);
        check("sb_busy3", 32'(busy), 32'd0);
`else
        // Read-modify-write byte store to lane 1
        request(1'b1, 32'h201, 32'h0, 32'h0000005A);
        step();
        store_req = 1'b0;
        check("rmw_re",   32'(mem_re), 32'd1);
        check("rmw_we",   32'(mem_we), 32'd0);
        check("rmw_addr", mem_addr, 32'h200);
        mem_rdata = 32'h11223344;
        mem_ack   = 1'b1;
        step();
        check("rmw_re2",   32'(mem_re), 32'd0);
        check("rmw_we2",   32'(mem_we), 32'd1);
        check("rmw_wdata", mem_wdata, 32'h11225A44);
        check("rmw_wstrb", 32'(mem_wstrb), 32'hF);
        check("rmw_ndone", 32'(done), 32'd0);
        step();
        mem_ack = 1'b0;
        check("rmw_done",  32'(done), 32'd1);
        check("rmw_we3",   32'(mem_we), 32'd0);
        step();
        check("rmw_done4", 32'(done), 32'd0);
        check("rmw_busy4", 32'(busy), 32'd0);
`endif

        // Misaligned word store
        request(1'b0, 32'h102, 32'h12345678, 32'h0);
        step();
        store_req = 1'b0;
        check("mis_err",  32'(err), 32'd1);
        check("mis_busy", 32'(busy), 32'd0);
        check("mis_we",   32'(mem_we), 32'd0);
        step();
        check("mis_err2", 32'(err), 32'd0);
        check("mis_we2",  32'(mem_we), 32'd0);
        check("mis_busy2", 32'(busy), 32'd0);

        // Timeout with no ack; second request during the wait is ignored
        request(1'b0, 32'h300, 32'hCAFEF00D, 32'h0);
        step();
        check("to_we1", 32'(mem_we), 32'd1);
        request(1'b0, 32'h400, 32'h0BADBEEF, 32'h0);
        step();
        store_req = 1'b0;
        check("to_we2",   32'(mem_we), 32'd1);
        check("to_addr2", mem_addr, 32'h300);
        check("to_data2", mem_wdata, 32'hCAFEF00D);
        step();
        check("to_we3",  32'(mem_we), 32'd1);
        step();
        check("to_we4",  32'(mem_we), 32'd1);
        check("to_err4", 32'(err), 32'd0);
        step();
        check("to_we5",   32'(mem_we), 32'd0);
        check("to_err5",  32'(err), 32'd1);
        check("to_done5", 32'(done), 32'd0);
        check("to_busy5", 32'(busy), 32'd0);
        step();
        check("to_err6",  32'(err), 32'd0);
        check("to_done6", 32'(done), 32'd0);

        // Reset during a write phase, then a normal store
        request(1'b0, 32'h500, 32'h55AA55AA, 32'h0);
        step();
        store_req = 1'b0;
        check("rw_we", 32'(mem_we), 32'd1);
        nRst = 1'b0;
        step();
        check("rw_we0",    32'(mem_we), 32'd0);
        check("rw_busy0",  32'(busy), 32'd0);
        check("rw_addr0",  mem_addr, 32'd0);
        check("rw_wdata0", mem_wdata, 32'd0);
        check("rw_wstrb0", 32'(mem_wstrb), 32'd0);
        check("rw_done0",  32'(done), 32'd0);
        check("rw_err0",   32'(err), 32'd0);
        nRst = 1'b1;
        request(1'b0, 32'h600, 32'h12345678, 32'h0);
        step();
        store_req = 1'b0;
        check("rw_we1",    32'(mem_we), 32'd1);
        check("rw_addr1",  mem_addr, 32'h600);
        check("rw_wdata1", mem_wdata, 32'h12345678);
        check("rw_err1",   32'(err), 32'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("rw_done2", 32'(done), 32'd1);
        step();
        check("rw_busy3", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
